// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: WIDTH-bit GPIO block with an output register, synchronised and
// debounced inputs, per-bit rising/falling edge detection and a single
// interrupt line built from PENDING & IRQ_EN.
// The software port is word addressed. Writes take effect in a single cycle,
// and reads are registered with one cycle of latency.

module gpio_irq_ctrl #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    input  logic             reg_we,
    input  logic             reg_re,
    input  logic [2:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             ext_irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_IN      = 3'd1;
    localparam logic [2:0] ADDR_RISE_EN = 3'd2;
    localparam logic [2:0] ADDR_FALL_EN = 3'd3;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd4;
    localparam logic [2:0] ADDR_PENDING = 3'd5;

    // Input path state
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_deb;
    logic [WIDTH-1:0] deb_flip;
    logic [CNT_W-1:0] deb_cnt      [WIDTH];
    logic [CNT_W-1:0] deb_cnt_next [WIDTH];

    // Software-visible registers
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] pending;

    // Bus decode and event logic
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] pending_next;
    logic [31:0]      rd_mux;
    logic             wr_out;
    logic             wr_rise_en;
    logic             wr_fall_en;
    logic             wr_irq_en;
    logic             wr_pending;
    logic             wdata_unused;

    // Only the low WIDTH bits of the write bus carry register data.
    assign wdata_w      = reg_wdata[WIDTH-1:0];
    assign wdata_unused = ^reg_wdata;

    assign wr_out     = reg_we && (reg_addr == ADDR_OUT);
    assign wr_rise_en = reg_we && (reg_addr == ADDR_RISE_EN);
    assign wr_fall_en = reg_we && (reg_addr == ADDR_FALL_EN);
    assign wr_irq_en  = reg_we && (reg_addr == ADDR_IRQ_EN);
    assign wr_pending = reg_we && (reg_addr == ADDR_PENDING);

    // Multi-flop synchroniser bringing the asynchronous pins into sys_clk
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Per-bit stability counter: a bit flips only after DEBOUNCE_CYCLES disagreeing cycles
    always_comb begin
        deb_flip = '0;
        for (int b = 0; b < WIDTH; b++) begin
            deb_cnt_next[b] = '0;
            if (in_sync[b] != in_deb[b]) begin
                if (deb_cnt[b] == CNT_LAST) begin
                    deb_flip[b] = 1'b1;
                end else begin
                    deb_cnt_next[b] = deb_cnt[b] + CNT_ONE;
                end
            end
        end
    end

    // Debounced value and counters
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_deb <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            in_deb <= in_deb ^ deb_flip;
            for (int b = 0; b < WIDTH; b++) begin
                deb_cnt[b] <= deb_cnt_next[b];
            end
        end
    end

    // Edge events are taken from the debounced transition itself, so they land
    // on the same edge as the new debounced value. A simultaneous W1C loses to a new event.
    always_comb begin
        rise_evt     = deb_flip & ~in_deb & rise_en;
        fall_evt     = deb_flip &  in_deb & fall_en;
        w1c_mask     = wr_pending ? wdata_w : '0;
        pending_next = (pending & ~w1c_mask) | rise_evt | fall_evt;
    end

    // Software register writes and pending-latch update
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
            rise_en <= '0;
            fall_en <= '0;
            irq_en  <= '0;
            pending <= '0;
        end else begin
            if (wr_out) begin
                out_reg <= wdata_w;
            end
            if (wr_rise_en) begin
                rise_en <= wdata_w;
            end
            if (wr_fall_en) begin
                fall_en <= wdata_w;
            end
            if (wr_irq_en) begin
                irq_en <= wdata_w;
            end
            pending <= pending_next;
        end
    end

    // Read mux over current (pre-write) register contents, zero-extended to 32 bits
    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_OUT:     rd_mux = 32'(out_reg);
            ADDR_IN:      rd_mux = 32'(in_deb);
            ADDR_RISE_EN: rd_mux = 32'(rise_en);
            ADDR_FALL_EN: rd_mux = 32'(fall_en);
            ADDR_IRQ_EN:  rd_mux = 32'(irq_en);
            ADDR_PENDING: rd_mux = 32'(pending);
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, held while no read is requested
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata <= '0;
        end else if (reg_re) begin
            reg_rdata <= rd_mux;
        end
    end

    assign gpio_o  = out_reg;
    assign ext_irq = |(pending & irq_en);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model: pin samples are kept per clock edge in a queue, and a
// debounced bit flips when the last DEBOUNCE_CYCLES synchronised samples all
// disagree with it.

module tb_gpio_irq_ctrl;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         sys_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic [W-1:0] gpio_i  = '0;
    logic [W-1:0] gpio_o;
    logic         reg_we  = 1'b0;
    logic         reg_re  = 1'b0;
    logic [2:0]   reg_addr = '0;
    logic [31:0]  reg_wdata = '0;
    logic [31:0]  reg_rdata;
    logic         ext_irq;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    logic [W-1:0] m_out, m_rise, m_fall, m_irq, m_pend, m_d;
    logic [31:0]  m_rdata;
    logic [W-1:0] hist[$];

    gpio_irq_ctrl #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .ext_irq  (ext_irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_rise = '0; m_fall = '0; m_irq = '0; m_pend = '0; m_d = '0;
        m_rdata = '0;
        hist.delete();
    endtask

    task automatic check_outputs();
        check("gpio_o", 32'(gpio_o), 32'(m_out));
        check("ext_irq", 32'(ext_irq), 32'(|(m_pend & m_irq)));
        check("reg_rdata", reg_rdata, m_rdata);
    endtask

    // One clock edge: capture the inputs held across the edge, advance the model, then compare.
    task automatic tick();
        logic         we, re;
        logic [2:0]   a;
        logic [31:0]  wd;
        logic [W-1:0] pin, flip, hv, rise_ev, fall_ev, w1c;
        int           n, idx;
        we = reg_we; re = reg_re; a = reg_addr; wd = reg_wdata; pin = gpio_i;
        @(posedge sys_clk);
        hist.push_back(pin);
        n = hist.size() - 1;
        for (int b = 0; b < W; b++) begin
            flip[b] = 1'b1;
            for (int i = 0; i < DC; i++) begin
                idx = n - SS - i;
                hv  = (idx < 0) ? '0 : hist[idx];
                if (hv[b] == m_d[b]) flip[b] = 1'b0;
            end
        end
        if (re) begin
            case (a)
                3'd0: m_rdata = 32'(m_out);
                3'd1: m_rdata = 32'(m_d);
                3'd2: m_rdata = 32'(m_rise);
                3'd3: m_rdata = 32'(m_fall);
                3'd4: m_rdata = 32'(m_irq);
                3'd5: m_rdata = 32'(m_pend);
                default: m_rdata = 32'd0;
            endcase
        end
        rise_ev = flip & ~m_d & m_rise;
        fall_ev = flip &  m_d & m_fall;
        w1c     = (we && a == 3'd5) ? wd[W-1:0] : '0;
        m_pend  = (m_pend & ~w1c) | rise_ev | fall_ev;
        if (we) begin
            case (a)
                3'd0: m_out  = wd[W-1:0];
                3'd2: m_rise = wd[W-1:0];
                3'd3: m_fall = wd[W-1:0];
                3'd4: m_irq  = wd[W-1:0];
                default: ;
            endcase
        end
        m_d = m_d ^ flip;
        #1;
        check_outputs();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        reg_re = 1'b1; reg_addr = a;
        tick();
        reg_re = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_gpio_o", 32'(gpio_o), 32'h0);
        check("reset_rdata", reg_rdata, 32'h0);
        check("reset_ext_irq", 32'(ext_irq), 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Output register
        wr(3'd0, 32'hFFFF_FFA5);
        check("out_on_write_edge", 32'(gpio_o), 32'hA5);
        rd(3'd0);
        check("out_readback", reg_rdata, 32'h0000_00A5);

        // Rising edge with interrupt on bit 0
        wr(3'd2, 32'h01);
        wr(3'd4, 32'h01);
        gpio_i[0] = 1'b1;
        repeat (5) tick();
        check("rise_before_edge6", 32'(ext_irq), 32'h0);
        tick();
        check("rise_irq_edge6", 32'(ext_irq), 32'h1);
        rd(3'd1);
        check("rise_in", reg_rdata, 32'h01);
        rd(3'd5);
        check("rise_pending", reg_rdata, 32'h01);
        wr(3'd5, 32'h01);
        check("rise_w1c_irq", 32'(ext_irq), 32'h0);

        // Glitch rejection on bit 3
        gpio_i[3] = 1'b1;
        repeat (3) tick();
        gpio_i[3] = 1'b0;
        repeat (8) tick();
        rd(3'd1);
        check("glitch_in", reg_rdata, 32'h01);
        rd(3'd5);
        check("glitch_pending", reg_rdata, 32'h00);
        check("glitch_irq", 32'(ext_irq), 32'h0);

        // Falling edge on bit 7, masked then unmasked
        gpio_i[7] = 1'b1;
        repeat (10) tick();
        wr(3'd3, 32'h80);
        wr(3'd4, 32'h00);
        gpio_i[7] = 1'b0;
        repeat (6) tick();
        rd(3'd5);
        check("fall_pending", reg_rdata, 32'h80);
        check("fall_masked_irq", 32'(ext_irq), 32'h0);
        wr(3'd4, 32'h80);
        check("fall_unmasked_irq", 32'(ext_irq), 32'h1);
        wr(3'd5, 32'hFF);

        // W1C of bit 2 on the same edge its rising event fires
        wr(3'd2, 32'h05);
        gpio_i[2] = 1'b1;
        repeat (5) tick();
        wr(3'd5, 32'h04);
        rd(3'd5);
        check("collision_pending", reg_rdata, 32'h04);

        // Reset mid-operation with OUT=FF, PENDING=0F
        wr(3'd5, 32'hFF);
        wr(3'd0, 32'hFF);
        wr(3'd2, 32'h0F);
        wr(3'd3, 32'h0F);
        wr(3'd4, 32'h0F);
        gpio_i = gpio_i ^ 8'h0F;
        repeat (8) tick();
        rd(3'd5);
        check("pre_reset_pending", reg_rdata, 32'h0F);
        check("pre_reset_irq", 32'(ext_irq), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_gpio_o", 32'(gpio_o), 32'h0);
        check("async_reset_irq", 32'(ext_irq), 32'h0);
        check("async_reset_rdata", reg_rdata, 32'h0);
        model_reset();
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            check("post_reset_read", reg_rdata, 32'h0);
        end

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) gpio_i[$urandom_range(0, W-1)] ^= 1'b1;
            reg_we    = ($urandom_range(0, 3) == 0);
            reg_re    = ($urandom_range(0, 1) == 1);
            reg_addr  = 3'($urandom_range(0, 7));
            reg_wdata = $urandom;
            tick();
        end
        reg_we = 1'b0;
        reg_re = 1'b0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
